// File: rtl/axicb_resp_dispatcher.sv
// ---------------------------------------------------------------------------
// axicb_resp_dispatcher
//
// Routes downstream responses back to upstream requesters in the order their
// grants were issued. Each accepted one-hot grant is stored in a small FIFO.
// The head entry selects which requester receives the current response. A
// response burst is forwarded beat by beat, and the head is popped only on
// the handshake of the last beat.
//
// Parameters
//   REQ_NB  : number of requesters. Only 4 and 8 are supported.
//   OSTD_NB : grant FIFO depth. Only powers of 2 from 2 to 16 are supported.
//   DATA_W  : response payload width.
//
// Ports
//   aclk, areset, srst : clock, async active-high reset, sync active-high reset
//   grant_valid/grant  : one-hot grant from the arbiter
//   grant_ready        : FIFO not full
//   rsp_valid/rsp_ready, rsp_data/rsp_last : downstream response channel
//   m_valid/m_ready    : per-requester response handshake
//   m_data/m_last      : shared response payload (zero-latency pass-through)
//   empty/full         : registered queue status
//   err_grant          : one-cycle pulse after a non-one-hot grant was dropped
// ---------------------------------------------------------------------------
module axicb_resp_dispatcher #(
    parameter int REQ_NB  = 4,
    parameter int OSTD_NB = 4,
    parameter int DATA_W  = 8
) (
    input  logic              aclk,
    input  logic              areset,
    input  logic              srst,
    input  logic              grant_valid,
    input  logic [REQ_NB-1:0] grant,
    output logic              grant_ready,
    input  logic              rsp_valid,
    output logic              rsp_ready,
    input  logic [DATA_W-1:0] rsp_data,
    input  logic              rsp_last,
    output logic [REQ_NB-1:0] m_valid,
    input  logic [REQ_NB-1:0] m_ready,
    output logic [DATA_W-1:0] m_data,
    output logic              m_last,
    output logic              empty,
    output logic              full,
    output logic              err_grant
);

    localparam int PTR_W = $clog2(OSTD_NB);
    localparam int CNT_W = PTR_W + 1;

    localparam logic [REQ_NB-1:0] REQ_ZERO = {REQ_NB{1'b0}};
    localparam logic [REQ_NB-1:0] REQ_ONE  = {{(REQ_NB-1){1'b0}}, 1'b1};
    localparam logic [PTR_W-1:0]  PTR_ZERO = {PTR_W{1'b0}};
    localparam logic [PTR_W-1:0]  PTR_ONE  = {{(PTR_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0]  CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0]  CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0]  CNT_FULL = CNT_W'(OSTD_NB);

    // True when exactly one bit of the grant vector is set.
    function automatic logic is_onehot(input logic [REQ_NB-1:0] v);
        return (v != REQ_ZERO) && ((v & (v - REQ_ONE)) == REQ_ZERO);
    endfunction

    logic [REQ_NB-1:0] mem_r [OSTD_NB];
    logic [PTR_W-1:0]  wr_ptr_r;
    logic [PTR_W-1:0]  rd_ptr_r;
    logic [CNT_W-1:0]  count_r;
    logic [CNT_W-1:0]  count_nxt_s;
    logic              empty_r;
    logic              full_r;
    logic              err_grant_r;
    logic              grant_hs_s;
    logic              push_s;
    logic              bad_grant_s;
    logic              pop_s;
    logic [REQ_NB-1:0] head_s;

    // Every handshaked grant is consumed. Only a one-hot grant is stored.
    assign grant_hs_s  = grant_valid & ~full_r;
    assign push_s      = grant_hs_s & is_onehot(grant);
    assign bad_grant_s = grant_hs_s & ~is_onehot(grant);
    assign pop_s       = rsp_valid & rsp_ready & rsp_last;

    // Head selection. It is forced to zero while empty, so stale storage
    // contents cannot drive any routing output.
    always_comb begin
        head_s = REQ_ZERO;
        if (empty_r) begin
            head_s = REQ_ZERO;
        end else begin
            head_s = mem_r[rd_ptr_r];
        end
    end

    // Next occupancy. A push and a pop in the same cycle cancel each other.
    always_comb begin
        count_nxt_s = count_r;
        if (push_s && !pop_s) begin
            count_nxt_s = count_r + CNT_ONE;
        end else if (pop_s && !push_s) begin
            count_nxt_s = count_r - CNT_ONE;
        end else begin
            count_nxt_s = count_r;
        end
    end

    // Pointers, occupancy, registered status flags and the error pulse.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            wr_ptr_r    <= PTR_ZERO;
            rd_ptr_r    <= PTR_ZERO;
            count_r     <= CNT_ZERO;
            empty_r     <= 1'b1;
            full_r      <= 1'b0;
            err_grant_r <= 1'b0;
        end else if (srst) begin
            wr_ptr_r    <= PTR_ZERO;
            rd_ptr_r    <= PTR_ZERO;
            count_r     <= CNT_ZERO;
            empty_r     <= 1'b1;
            full_r      <= 1'b0;
            err_grant_r <= 1'b0;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end else begin
                wr_ptr_r <= wr_ptr_r;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end else begin
                rd_ptr_r <= rd_ptr_r;
            end
            count_r     <= count_nxt_s;
            empty_r     <= (count_nxt_s == CNT_ZERO);
            full_r      <= (count_nxt_s == CNT_FULL);
            err_grant_r <= bad_grant_s;
        end
    end

    // Grant storage. It is not reset because it is masked while empty.
    always_ff @(posedge aclk) begin
        if (push_s && !srst) begin
            mem_r[wr_ptr_r] <= grant;
        end else begin
            mem_r[wr_ptr_r] <= mem_r[wr_ptr_r];
        end
    end

    assign grant_ready = ~full_r;
    assign m_valid     = head_s & {REQ_NB{rsp_valid}};
    assign rsp_ready   = |(head_s & m_ready);
    assign m_data      = rsp_data;
    assign m_last      = rsp_last;
    assign empty       = empty_r;
    assign full        = full_r;
    assign err_grant   = err_grant_r;

endmodule

// File: tb/tb_axicb_resp_dispatcher.sv
// ---------------------------------------------------------------------------
// Testbench for axicb_resp_dispatcher (REQ_NB=4, OSTD_NB=4, DATA_W=8).
// The reference model is a queue of pending grants. The expected outputs are
// derived from the queue contents and the current inputs.
// ---------------------------------------------------------------------------
module tb_axicb_resp_dispatcher;

    localparam int REQ_NB  = 4;
    localparam int OSTD_NB = 4;
    localparam int DATA_W  = 8;

    logic              aclk = 1'b0;
    logic              areset;
    logic              srst;
    logic              grant_valid;
    logic [REQ_NB-1:0] grant;
    logic              grant_ready;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_data;
    logic              rsp_last;
    logic [REQ_NB-1:0] m_valid;
    logic [REQ_NB-1:0] m_ready;
    logic [DATA_W-1:0] m_data;
    logic              m_last;
    logic              empty;
    logic              full;
    logic              err_grant;

    axicb_resp_dispatcher #(
        .REQ_NB (REQ_NB),
        .OSTD_NB(OSTD_NB),
        .DATA_W (DATA_W)
    ) dut (
        .aclk       (aclk),
        .areset     (areset),
        .srst       (srst),
        .grant_valid(grant_valid),
        .grant      (grant),
        .grant_ready(grant_ready),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_data   (rsp_data),
        .rsp_last   (rsp_last),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_data     (m_data),
        .m_last     (m_last),
        .empty      (empty),
        .full       (full),
        .err_grant  (err_grant)
    );

    always #5 aclk = ~aclk;

    int n_checks = 0;
    int n_fail   = 0;

    logic [REQ_NB-1:0] q[$];
    logic              err_exp = 1'b0;

    // Single comparison point: count the check and report any mismatch.
    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Check every output against the model while outputs are quiet.
    task automatic check_outputs();
        logic [REQ_NB-1:0] head;
        head = (q.size() == 0) ? 4'b0000 : q[0];
        check_eq("empty",       {31'd0, empty},       {31'd0, q.size() == 0});
        check_eq("full",        {31'd0, full},        {31'd0, q.size() == OSTD_NB});
        check_eq("grant_ready", {31'd0, grant_ready}, {31'd0, q.size() != OSTD_NB});
        check_eq("err_grant",   {31'd0, err_grant},   {31'd0, err_exp});
        check_eq("m_valid",     {28'd0, m_valid},     {28'd0, rsp_valid ? head : 4'b0000});
        check_eq("rsp_ready",   {31'd0, rsp_ready},   {31'd0, (head & m_ready) != 4'b0000});
        check_eq("m_data",      {24'd0, m_data},      {24'd0, rsp_data});
        check_eq("m_last",      {31'd0, m_last},      {31'd0, rsp_last});
    endtask

    // One clock cycle: drive the inputs, check the outputs, advance the model.
    task automatic step(input logic gv, input logic [3:0] g, input logic rv,
                        input logic [7:0] rd, input logic rl,
                        input logic [3:0] mr, input logic sr);
        logic [REQ_NB-1:0] head;
        logic              acc;
        logic              pop;
        @(negedge aclk);
        grant_valid = gv; grant = g; rsp_valid = rv; rsp_data = rd;
        rsp_last = rl; m_ready = mr; srst = sr;
        #1;
        check_outputs();
        head = (q.size() == 0) ? 4'b0000 : q[0];
        acc  = gv && (q.size() != OSTD_NB);
        pop  = rv && rl && ((head & mr) != 4'b0000);
        if (sr) begin
            q.delete();
            err_exp = 1'b0;
        end else begin
            if (pop) void'(q.pop_front());
            if (acc && ($countones(g) == 1)) q.push_back(g);
            err_exp = acc && ($countones(g) != 1);
        end
    endtask

    task automatic idle();
        step(1'b0, 4'b0000, 1'b0, 8'h00, 1'b0, 4'b0000, 1'b0);
    endtask

    task automatic push(input logic [3:0] g);
        step(1'b1, g, 1'b0, 8'h00, 1'b0, 4'b0000, 1'b0);
    endtask

    // Assert the asynchronous reset between clock edges and check it at once.
    task automatic async_reset_mid_response();
        @(negedge aclk);
        grant_valid = 1'b0; rsp_valid = 1'b1; rsp_last = 1'b0; m_ready = 4'b1111;
        areset = 1'b1;
        #1;
        q.delete();
        err_exp = 1'b0;
        check_outputs();
        @(negedge aclk);
        areset = 1'b0;
        rsp_valid = 1'b0;
    endtask

    initial begin
        areset = 1'b1; srst = 1'b0; grant_valid = 1'b0; grant = 4'b0000;
        rsp_valid = 1'b0; rsp_data = 8'h00; rsp_last = 1'b0; m_ready = 4'b0000;
        #2;
        check_outputs();
        @(negedge aclk);
        areset = 1'b0;

        // In-order routing of three single-beat responses.
        push(4'b0001); push(4'b0100); push(4'b1000);
        step(1'b0, 4'b0000, 1'b1, 8'hD0, 1'b1, 4'b1111, 1'b0);
        step(1'b0, 4'b0000, 1'b1, 8'hD1, 1'b1, 4'b1111, 1'b0);
        step(1'b0, 4'b0000, 1'b1, 8'hD2, 1'b1, 4'b1111, 1'b0);
        idle();

        // Fill to full, try a fifth grant, then pop one entry.
        push(4'b0001); push(4'b0010); push(4'b0100); push(4'b1000);
        push(4'b0001);
        step(1'b0, 4'b0000, 1'b1, 8'h11, 1'b1, 4'b0001, 1'b0);
        idle();
        for (int i = 0; i < 3; i++) step(1'b0, 4'b0000, 1'b1, 8'h20, 1'b1, 4'b1111, 1'b0);
        idle();

        // A three-beat response with beat 2 stalled for two cycles.
        push(4'b0010);
        step(1'b0, 4'b0000, 1'b1, 8'h31, 1'b0, 4'b0010, 1'b0);
        step(1'b0, 4'b0000, 1'b1, 8'h32, 1'b0, 4'b1101, 1'b0);
        step(1'b0, 4'b0000, 1'b1, 8'h32, 1'b0, 4'b1101, 1'b0);
        step(1'b0, 4'b0000, 1'b1, 8'h32, 1'b0, 4'b0010, 1'b0);
        step(1'b0, 4'b0000, 1'b1, 8'h33, 1'b1, 4'b0010, 1'b0);
        idle();

        // Grants that are not one-hot are dropped and flagged.
        push(4'b0000); push(4'b0110); idle(); idle();

        // A response while empty stalls until a grant arrives.
        step(1'b0, 4'b0000, 1'b1, 8'h44, 1'b1, 4'b1111, 1'b0);
        step(1'b1, 4'b1000, 1'b1, 8'h44, 1'b1, 4'b1111, 1'b0);
        step(1'b0, 4'b0000, 1'b1, 8'h44, 1'b1, 4'b1111, 1'b0);
        idle();

        // Reset in the middle of a response: asynchronous, then synchronous.
        push(4'b0100); push(4'b0001); push(4'b0010);
        step(1'b0, 4'b0000, 1'b1, 8'h55, 1'b0, 4'b1111, 1'b0);
        async_reset_mid_response();
        step(1'b0, 4'b0000, 1'b1, 8'h56, 1'b1, 4'b1111, 1'b0);
        push(4'b0100); push(4'b0001); push(4'b0010);
        step(1'b0, 4'b0000, 1'b1, 8'h57, 1'b0, 4'b1111, 1'b0);
        step(1'b1, 4'b1000, 1'b1, 8'h58, 1'b0, 4'b1111, 1'b1);
        step(1'b0, 4'b0000, 1'b1, 8'h59, 1'b1, 4'b1111, 1'b0);
        idle();

        // Randomized traffic that includes malformed grants and occasional srst.
        for (int i = 0; i < 2000; i++) begin
            logic [3:0] g;
            int         r;
            r = $urandom_range(0, 9);
            g = (r < 8) ? (4'b0001 << (r % 4)) : 4'($urandom);
            step(1'($urandom_range(0, 1)), g, 1'($urandom_range(0, 3) != 0),
                 8'($urandom), 1'($urandom_range(0, 2) == 0), 4'($urandom),
                 1'($urandom_range(0, 63) == 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
